// File: rtl/fetch_stage.sv
// Instruction fetch: one request in flight, one instruction buffered for decode.
// Redirects squash an in-flight request by marking its eventual ack for discard.
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_ready,
  input  logic               branch_take,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [4:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [15:0]        fetch_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [4:0] OPC_NOP = 5'b10111;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic              squash;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      squash      <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          req_addr <= pc;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            // A pending or same-cycle redirect makes this data stale; reissue at the new PC.
            if (squash || branch_take) begin
              squash   <= 1'b0;
              req_addr <= branch_take ? branch_target : pc;
              pc       <= branch_take ? branch_target : pc;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= req_addr;
              pc       <= req_addr + 1'b1;
              state    <= S_FULL;
            end
          end else if (branch_take) begin
            pc     <= branch_target;
            squash <= 1'b1;
          end
        end
        S_FULL: begin
          if (branch_take) begin
            pc       <= branch_target;
            req_addr <= branch_target;
            state    <= S_REQ;
          end else if (id_ready) begin
            fetch_count <= fetch_count + 16'd1;
            req_addr    <= pc;
            state       <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = req_addr;
  assign if_valid  = (state == S_FULL);
  assign if_opcode = if_valid ? if_instr[INSTR_W-1 -: 5] : OPC_NOP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against an
// in-order delivery model (next expected PC, last redirect target wins).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        imem_req, imem_ack, id_ready, branch_take, if_valid;
  logic [15:0] imem_addr, branch_target, if_pc, fetch_count;
  logic [31:0] imem_rdata, if_instr;
  logic [4:0]  if_opcode;

  logic        imem_req_b, imem_ack_b, id_ready_b, if_valid_b;
  logic [15:0] imem_addr_b, if_pc_b, fetch_count_b;
  logic [31:0] imem_rdata_b, if_instr_b;
  logic [4:0]  if_opcode_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .branch_take(branch_take), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc),
    .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
    .id_ready(id_ready_b), .branch_take(1'b0), .branch_target(16'h0000),
    .if_valid(if_valid_b), .if_instr(if_instr_b), .if_opcode(if_opcode_b), .if_pc(if_pc_b),
    .fetch_count(fetch_count_b)
  );

  function automatic logic [31:0] mem(input logic [15:0] a);
    return {a[4:0] + 5'd3, 11'h5A5, a};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 8;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
    if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", if_valid); end
    if (if_opcode !== 5'b10111) begin n_err++; $display("FAIL rst_opcode got %b want 10111", if_opcode); end
    if (fetch_count !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fetch_count); end
    if (if_pc !== 16'h0000) begin n_err++; $display("FAIL rst_pc got %h want 0000", if_pc); end
    if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", if_instr); end
    if (imem_addr_b !== 16'hFFFF) begin n_err++; $display("FAIL rst_addr_b got %h want ffff", imem_addr_b); end
  endtask

  task automatic test_sequential();
    reset_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp += 3;
      if (imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req[%0d] got %b want 1", k, imem_req); end
      if (imem_addr !== 16'(k)) begin n_err++; $display("FAIL seq_addr[%0d] got %h want %h", k, imem_addr, 16'(k)); end
      if (if_valid !== 1'b0) begin n_err++; $display("FAIL seq_novalid[%0d] got %b want 0", k, if_valid); end
      imem_ack = 1'b1;
      imem_rdata = 32'h0800_0000 | 32'(k);
      id_ready = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      n_cmp += 6;
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got %b want 1", k, if_valid); end
      if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_reqlow[%0d] got %b want 0", k, imem_req); end
      if (if_pc !== 16'(k)) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", k, if_pc, 16'(k)); end
      if (if_instr !== (32'h0800_0000 | 32'(k))) begin n_err++; $display("FAIL seq_instr[%0d] got %h", k, if_instr); end
      if (if_opcode !== 5'b00001) begin n_err++; $display("FAIL seq_opcode[%0d] got %b want 00001", k, if_opcode); end
      if (fetch_count !== 16'(k)) begin n_err++; $display("FAIL seq_count[%0d] got %0d want %0d", k, fetch_count, k); end
      @(negedge clk);
    end
    n_cmp += 2;
    if (fetch_count !== 16'd3) begin n_err++; $display("FAIL seq_count_end got %0d want 3", fetch_count); end
    if (imem_addr !== 16'd3) begin n_err++; $display("FAIL seq_addr_end got %h want 0003", imem_addr); end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1;
    imem_rdata = 32'h0800_0003;
    id_ready = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp += 5;
      if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", i, if_valid); end
      if (if_pc !== 16'd3) begin n_err++; $display("FAIL stall_pc[%0d] got %h want 0003", i, if_pc); end
      if (if_instr !== 32'h0800_0003) begin n_err++; $display("FAIL stall_instr[%0d] got %h", i, if_instr); end
      if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
      if (fetch_count !== 16'd3) begin n_err++; $display("FAIL stall_count[%0d] got %0d want 3", i, fetch_count); end
      @(negedge clk);
    end
    id_ready = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (imem_addr !== 16'd4) begin n_err++; $display("FAIL stall_next_addr got %h want 0004", imem_addr); end
    if (fetch_count !== 16'd4) begin n_err++; $display("FAIL stall_next_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_branch_req();
    id_ready = 1'b0;
    branch_take = 1'b1;
    branch_target = 16'h0040;
    @(negedge clk);
    branch_take = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp += 2;
      if (imem_req !== 1'b1) begin n_err++; $display("FAIL brq_req[%0d] got %b want 1", i, imem_req); end
      if (imem_addr !== 16'd4) begin n_err++; $display("FAIL brq_hold[%0d] got %h want 0004", i, imem_addr); end
      if (i == 2) begin
        imem_ack = 1'b1;
        imem_rdata = 32'h0800_0004;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    n_cmp += 2;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL brq_discard got valid %b want 0", if_valid); end
    if (imem_addr !== 16'h0040) begin n_err++; $display("FAIL brq_newaddr got %h want 0040", imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = mem(16'h0040);
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp += 3;
    if (if_valid !== 1'b1) begin n_err++; $display("FAIL brq_valid got %b want 1", if_valid); end
    if (if_pc !== 16'h0040) begin n_err++; $display("FAIL brq_pc got %h want 0040", if_pc); end
    if (if_instr !== mem(16'h0040)) begin n_err++; $display("FAIL brq_instr got %h want %h", if_instr, mem(16'h0040)); end
  endtask

  task automatic test_branch_full();
    branch_take = 1'b1;
    branch_target = 16'h0123;
    id_ready = 1'b1;
    @(negedge clk);
    branch_take = 1'b0;
    id_ready = 1'b0;
    n_cmp += 4;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL brf_valid got %b want 0", if_valid); end
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL brf_req got %b want 1", imem_req); end
    if (imem_addr !== 16'h0123) begin n_err++; $display("FAIL brf_addr got %h want 0123", imem_addr); end
    if (fetch_count !== 16'd4) begin n_err++; $display("FAIL brf_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_wrap();
    n_cmp += 2;
    if (imem_req_b !== 1'b1) begin n_err++; $display("FAIL wrap_req got %b want 1", imem_req_b); end
    if (imem_addr_b !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr got %h want ffff", imem_addr_b); end
    imem_ack_b = 1'b1;
    imem_rdata_b = 32'hA5A5_0000;
    @(negedge clk);
    imem_ack_b = 1'b0;
    n_cmp += 3;
    if (if_valid_b !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b want 1", if_valid_b); end
    if (if_pc_b !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pc got %h want ffff", if_pc_b); end
    if (if_opcode_b !== 5'b10100) begin n_err++; $display("FAIL wrap_opcode got %b want 10100", if_opcode_b); end
    id_ready_b = 1'b1;
    @(negedge clk);
    id_ready_b = 1'b0;
    n_cmp += 4;
    if (imem_req_b !== 1'b1) begin n_err++; $display("FAIL wrap_req2 got %b want 1", imem_req_b); end
    if (imem_addr_b !== 16'h0000) begin n_err++; $display("FAIL wrap_next got %h want 0000", imem_addr_b); end
    if (fetch_count_b !== 16'd1) begin n_err++; $display("FAIL wrap_count got %0d want 1", fetch_count_b); end
    if (if_instr_b !== 32'hA5A5_0000) begin n_err++; $display("FAIL wrap_instr got %h", if_instr_b); end
  endtask

  task automatic test_reset_mid();
    n_cmp += 1;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_pre got req %b want 1", imem_req); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp += 5;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b want 0", imem_req); end
    if (if_opcode !== 5'b10111) begin n_err++; $display("FAIL rmid_opcode got %b want 10111", if_opcode); end
    if (fetch_count !== 16'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", fetch_count); end
    if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rmid_addr got %h want 0000", imem_addr); end
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", if_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp += 3;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_first_req got %b want 1", imem_req); end
    if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rmid_first_addr got %h want 0000", imem_addr); end
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale got valid %b want 0", if_valid); end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] exp_cnt;
    logic [15:0] prev_addr;
    logic        prev_wait;
    int          delivered;
    exp_pc = 16'h0000;
    exp_cnt = 16'd0;
    prev_addr = 16'h0000;
    prev_wait = 1'b0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      n_cmp += 3;
      if (fetch_count !== exp_cnt) begin n_err++; $display("FAIL rnd_count@%0d got %0d want %0d", c, fetch_count, exp_cnt); end
      if (imem_req && if_valid) begin n_err++; $display("FAIL rnd_exclusive@%0d got req=1 valid=1 want at most one", c); end
      if (if_opcode !== (if_valid ? if_instr[31:27] : 5'b10111)) begin
        n_err++; $display("FAIL rnd_opcode@%0d got %b valid=%b instr=%h", c, if_opcode, if_valid, if_instr);
      end
      if (prev_wait && imem_req) begin
        n_cmp++;
        if (imem_addr !== prev_addr) begin n_err++; $display("FAIL rnd_addr_hold@%0d got %h want %h", c, imem_addr, prev_addr); end
      end
      imem_ack = imem_req && ($urandom_range(0, 2) == 0);
      imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
      id_ready = ($urandom_range(0, 1) == 1);
      branch_take = (imem_req || if_valid) && ($urandom_range(0, 9) == 0);
      branch_target = 16'($urandom);
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (if_valid && id_ready && !branch_take) begin
        n_cmp += 2;
        if (if_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc@%0d got %h want %h", c, if_pc, exp_pc); end
        if (if_instr !== mem(exp_pc)) begin n_err++; $display("FAIL rnd_instr@%0d got %h want %h", c, if_instr, mem(exp_pc)); end
        exp_pc = exp_pc + 16'd1;
        exp_cnt = exp_cnt + 16'd1;
        delivered++;
      end
      if (branch_take) exp_pc = branch_target;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    branch_take = 1'b0;
    n_cmp += 2;
    if (fetch_count !== exp_cnt) begin n_err++; $display("FAIL rnd_count_end got %0d want %0d", fetch_count, exp_cnt); end
    if (delivered < 100) begin n_err++; $display("FAIL rnd_progress got %0d deliveries want >= 100", delivered); end
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    branch_take = 1'b0; branch_target = '0;
    imem_ack_b = 1'b0; imem_rdata_b = '0; id_ready_b = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_req();
    test_branch_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
